// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - DEPTH-entry IF/ID FIFO with valid/ready on both sides and one-cycle flush.
// Optional IF_ID_QUEUE_OCC_EN adds occ_out (occupancy) and flush_drop_out (flush discarded entries).
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              branch_flag_in,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              pre_to_take_in,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              pre_to_take_out
`ifdef IF_ID_QUEUE_OCC_EN
  ,
  output logic [PTR_W:0]    occ_out,
  output logic              flush_drop_out
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic              pred_mem_q [DEPTH];
  logic              pred_mem_d [DEPTH];

  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // Handshakes only count while the pipeline is globally enabled; flush overrides both.
  assign push = rdy_in & ~branch_flag_in & if_valid & ~full;
  assign pop  = rdy_in & ~branch_flag_in & id_ready & ~empty;

  always_comb begin
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (rdy_in) begin
      if (branch_flag_in) begin
        rp_d  = '0;
        wp_d  = '0;
        cnt_d = '0;
      end else begin
        if (push) wp_d = wp_q + PTR_W'(1);
        if (pop)  rp_d = rp_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
          2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    pred_mem_d = pred_mem_q;
    if (push) begin
      pc_mem_d[wp_q]   = if_pc;
      inst_mem_d[wp_q] = if_inst;
      pred_mem_d[wp_q] = pre_to_take_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage is never observed while empty, so it carries no reset.
  always_ff @(posedge clk_in) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
    pred_mem_q <= pred_mem_d;
  end

  assign id_valid        = ~empty;
  assign if_ready        = ~full;
  assign id_pc           = empty ? '0 : pc_mem_q[rp_q];
  assign id_inst         = empty ? '0 : inst_mem_q[rp_q];
  assign pre_to_take_out = empty ? 1'b0 : pred_mem_q[rp_q];

`ifdef IF_ID_QUEUE_OCC_EN
  logic flush_drop_q, flush_drop_d;

  always_comb begin
    flush_drop_d = flush_drop_q;
    if (rdy_in) flush_drop_d = branch_flag_in & (~empty | (if_valid & ~full));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) flush_drop_q <= 1'b0;
    else        flush_drop_q <= flush_drop_d;
  end

  assign occ_out        = cnt_q;
  assign flush_drop_out = flush_drop_q;
`endif

endmodule
